lb_fanout: RTL

- Parametrised local-bus fan-out between the board-base local bus (lb_clk domain) and N_CH application slots.
- Decodes the channel index from the top address bits and forwards each transaction, registered, to one slot.
- Tracks one outstanding read, returns the slot's data with a read-valid strobe, and answers unmapped or unresponsive slots with fixed values and error counters.
- Successor to the single hard-wired application slot: multi-slot, variable slot read latency, timeout.

---
 rtl/lb_fanout_pkg.sv | 16 +
 rtl/lb_fanout_if.sv | 36 +++
 rtl/lb_sat_cnt16.sv | 20 ++
 rtl/lb_fanout.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/lb_fanout_pkg.sv
// Shared types and constants for the lb_fanout local-bus fan-out.
package lb_fanout_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [31:0] DEF_TIMEOUT_VAL  = 32'hdead_beef;
  localparam logic [31:0] DEF_UNMAPPED_VAL = 32'hbad0_0000;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/lb_fanout_if.sv
// Local-bus bundle between the host side and the N_CH application slots.
interface lb_fanout_if #(
  parameter int N_CH    = 4,
  parameter int AW      = 24,
  parameter int CH_BITS = 4
);
  // Host: h_strobe qualifies one transaction for exactly one cycle, no ready;
  // a read completes with a one-cycle h_rd_valid while h_busy covers the
  // outstanding window. Slots: c_strobe[k] is a one-cycle request and
  // c_rd_valid[k] a one-cycle completion carrying c_rdata slice k.
  logic [AW-1:0]         h_addr;
  logic                  h_strobe;
  logic                  h_rd;
  logic                  h_write;
  logic [31:0]           h_wdata;
  logic [31:0]           h_rdata;
  logic                  h_rd_valid;
  logic                  h_busy;
  logic [AW-CH_BITS-1:0] c_addr;
  logic [31:0]           c_wdata;
  logic [N_CH-1:0]       c_strobe;
  logic                  c_rd;
  logic                  c_write;
  logic [N_CH*32-1:0]    c_rdata;
  logic [N_CH-1:0]       c_rd_valid;

  modport master (
    output h_addr, h_strobe, h_rd, h_write, h_wdata, c_rdata, c_rd_valid,
    input  h_rdata, h_rd_valid, h_busy, c_addr, c_wdata, c_strobe, c_rd, c_write
  );

  modport slave (
    input  h_addr, h_strobe, h_rd, h_write, h_wdata, c_rdata, c_rd_valid,
    output h_rdata, h_rd_valid, h_busy, c_addr, c_wdata, c_strobe, c_rd, c_write
  );
endinterface

// File: rtl/lb_sat_cnt16.sv
// 16-bit saturating event counter with synchronous clear (clear wins).
module lb_sat_cnt16
  import lb_fanout_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc16(cnt);
    end
  end

endmodule

// File: rtl/lb_fanout.sv
// Local-bus fan-out to N_CH slots with one outstanding read and timeout.
// Optional per-slot read statistics when LB_FANOUT_STATS_EN is defined.
module lb_fanout
  import lb_fanout_pkg::*;
#(
  parameter int          N_CH         = 4,
  parameter int          AW           = 24,
  parameter int          CH_BITS      = 4,
  parameter int          TIMEOUT      = 255,
  parameter logic [31:0] TIMEOUT_VAL  = DEF_TIMEOUT_VAL,
  parameter logic [31:0] UNMAPPED_VAL = DEF_UNMAPPED_VAL
) (
  input  logic         lb_clk,
  input  logic         rst,
  lb_fanout_if.slave   bus,
  output logic [15:0]  err_timeout,
  output logic [15:0]  err_drop,
  output state_t       dbg_state
`ifdef LB_FANOUT_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [N_CH*16-1:0]   stats_rd_cnt
`endif
);

  localparam logic [CH_BITS:0] N_CH_W   = (CH_BITS + 1)'(N_CH);
  localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);

  state_t               state;
  logic [CH_BITS-1:0]   sel;
  logic [15:0]          timer;

  logic [CH_BITS-1:0]   idx;
  logic                 mapped;
  logic [N_CH-1:0]      strobe_hot;
  logic [31:0]          sel_rdata;
  logic                 sel_valid;
  logic                 accept;
  logic                 drop;
  logic                 slot_done;
  logic                 timeout_hit;

  always_comb begin
    idx        = bus.h_addr[AW-1 -: CH_BITS];
    mapped     = ({1'b0, idx} < N_CH_W);
    strobe_hot = '0;
    sel_rdata  = '0;
    sel_valid  = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      strobe_hot[k] = (idx == CH_BITS'(k));
      if (sel == CH_BITS'(k)) begin
        sel_rdata = bus.c_rdata[32*k +: 32];
        sel_valid = bus.c_rd_valid[k];
      end
    end
    // h_busy spans WAIT plus the completion cycle, so it alone gates new work.
    accept      = bus.h_strobe && !bus.h_busy;
    drop        = bus.h_strobe && bus.h_busy;
    slot_done   = (state == WAIT) && sel_valid;
    timeout_hit = (state == WAIT) && !sel_valid && (timer == TMO_LAST);
  end

  always_ff @(posedge lb_clk) begin
    if (rst) begin
      state          <= IDLE;
      sel            <= '0;
      timer          <= '0;
      bus.c_addr     <= '0;
      bus.c_wdata    <= '0;
      bus.c_strobe   <= '0;
      bus.c_rd       <= 1'b0;
      bus.c_write    <= 1'b0;
      bus.h_rdata    <= '0;
      bus.h_rd_valid <= 1'b0;
      bus.h_busy     <= 1'b0;
    end else begin
      bus.c_strobe   <= '0;
      bus.h_rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.h_busy) begin
            bus.h_busy <= 1'b0;
          end
          if (accept) begin
            bus.c_addr  <= bus.h_addr[AW-CH_BITS-1:0];
            bus.c_wdata <= bus.h_wdata;
            bus.c_rd    <= bus.h_rd;
            bus.c_write <= bus.h_write;
            if (mapped) begin
              bus.c_strobe <= strobe_hot;
              if (bus.h_rd) begin
                state      <= WAIT;
                sel        <= idx;
                timer      <= '0;
                bus.h_busy <= 1'b1;
              end
            end else if (bus.h_rd) begin
              bus.h_rdata    <= UNMAPPED_VAL;
              bus.h_rd_valid <= 1'b1;
            end
          end
        end
        WAIT: begin
          timer <= timer + 16'd1;
          if (slot_done) begin
            bus.h_rdata    <= sel_rdata;
            bus.h_rd_valid <= 1'b1;
            state          <= IDLE;
          end else if (timeout_hit) begin
            bus.h_rdata    <= TIMEOUT_VAL;
            bus.h_rd_valid <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

  lb_sat_cnt16 u_err_timeout (
    .clk (lb_clk),
    .rst (rst),
    .clr (1'b0),
    .inc (timeout_hit),
    .cnt (err_timeout)
  );

  lb_sat_cnt16 u_err_drop (
    .clk (lb_clk),
    .rst (rst),
    .clr (1'b0),
    .inc (drop),
    .cnt (err_drop)
  );

`ifdef LB_FANOUT_STATS_EN
  for (genvar k = 0; k < N_CH; k++) begin : g_stats
    lb_sat_cnt16 u_rd_cnt (
      .clk (lb_clk),
      .rst (rst),
      .clr (stats_clr),
      .inc (slot_done && (sel == CH_BITS'(k))),
      .cnt (stats_rd_cnt[16*k +: 16])
    );
  end
`endif

endmodule
